// File: rtl/user_ip_axi4lite_regs.sv
// AXI4-lite slave register bank for the user IP: ID, scratch, control, status,
// free-running cycle counter and sticky W1C event bits behind a single-beat slave port.
module user_ip_axi4lite_regs #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 32,
   parameter logic [31:0] IP_ID  = 32'h5553_4552
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_W-1:0]     s_axi_wdata,
   input  logic [DATA_W/8-1:0]   s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_W-1:0]     s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [DATA_W-1:0]     s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [31:0]           ctrl_o,
   input  logic [31:0]           status_i,
   input  logic [7:0]            event_i
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [3:0] IDX_ID      = 4'h0;
   localparam logic [3:0] IDX_SCRATCH = 4'h1;
   localparam logic [3:0] IDX_CTRL    = 4'h2;
   localparam logic [3:0] IDX_STATUS  = 4'h3;
   localparam logic [3:0] IDX_CNT     = 4'h4;
   localparam logic [3:0] IDX_EVENT   = 4'h5;

   if (DATA_W != 32) begin : g_data_w_check
      $error("user_ip_axi4lite_regs: DATA_W must be 32");
   end

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   logic        awready_r, wready_r, aw_done_r, w_done_r, bvalid_r;
   logic [1:0]  bresp_r;
   logic [3:0]  aw_idx_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;
   logic        arready_r, rvalid_r;
   logic [1:0]  rresp_r;
   logic [31:0] rdata_r;
   logic [31:0] scratch_r, ctrl_r, cnt_r;
   logic [7:0]  event_r;
   logic        commit_s, wr_err_s, rd_err_s;
   logic [31:0] rd_data_s;
   logic [7:0]  evt_clr_s;
   logic        unused_s;

   assign commit_s = aw_done_r & w_done_r;
   assign wr_err_s = (aw_idx_r > IDX_EVENT);
   assign evt_clr_s = (commit_s && (aw_idx_r == IDX_EVENT) && wstrb_r[0]) ? wdata_r[7:0] : 8'h00;
   assign unused_s = ^{s_axi_awaddr[ADDR_W-1:6], s_axi_awaddr[1:0],
                       s_axi_araddr[ADDR_W-1:6], s_axi_araddr[1:0]};

   assign s_axi_awready = awready_r;
   assign s_axi_wready  = wready_r;
   assign s_axi_bvalid  = bvalid_r;
   assign s_axi_bresp   = bresp_r;
   assign s_axi_arready = arready_r;
   assign s_axi_rvalid  = rvalid_r;
   assign s_axi_rresp   = rresp_r;
   assign s_axi_rdata   = rdata_r;
   assign ctrl_o        = ctrl_r;

   // Write channel: capture AW and W independently, commit once both are held, then respond on B
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         awready_r <= 1'b1;
         wready_r  <= 1'b1;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
         aw_idx_r  <= 4'h0;
         wdata_r   <= 32'h0;
         wstrb_r   <= 4'h0;
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
      end else begin
         if (s_axi_awvalid && awready_r) begin
            awready_r <= 1'b0;
            aw_done_r <= 1'b1;
            aw_idx_r  <= s_axi_awaddr[5:2];
         end
         if (s_axi_wvalid && wready_r) begin
            wready_r <= 1'b0;
            w_done_r <= 1'b1;
            wdata_r  <= s_axi_wdata;
            wstrb_r  <= s_axi_wstrb;
         end
         if (commit_s) begin
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
         end
         if (bvalid_r && s_axi_bready) begin
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
         end
      end
   end

   // Register state: strobed writes, self-clearing counter clear, counter, sticky events (set beats clear)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scratch_r <= 32'h0;
         ctrl_r    <= 32'h0;
         cnt_r     <= 32'h0;
         event_r   <= 8'h00;
      end else begin
         if (commit_s && (aw_idx_r == IDX_SCRATCH)) begin
            scratch_r <= merge_bytes(scratch_r, wdata_r, wstrb_r);
         end
         if (commit_s && (aw_idx_r == IDX_CTRL)) begin
            ctrl_r <= merge_bytes(ctrl_r, wdata_r, wstrb_r);
         end else if (ctrl_r[1]) begin
            ctrl_r[1] <= 1'b0;
         end
         if (ctrl_r[1]) begin
            cnt_r <= 32'h0;
         end else if (ctrl_r[0]) begin
            cnt_r <= cnt_r + 32'd1;
         end
         event_r <= (event_r & ~evt_clr_s) | event_i;
      end
   end

   // Read decode of the current AR address
   always_comb begin
      rd_data_s = 32'h0;
      rd_err_s  = 1'b0;
      case (s_axi_araddr[5:2])
         IDX_ID:      rd_data_s = IP_ID;
         IDX_SCRATCH: rd_data_s = scratch_r;
         IDX_CTRL:    rd_data_s = ctrl_r;
         IDX_STATUS:  rd_data_s = status_i;
         IDX_CNT:     rd_data_s = cnt_r;
         IDX_EVENT:   rd_data_s = {24'h0, event_r};
         default:     rd_err_s  = 1'b1;
      endcase
   end

   // Read channel: register data on AR handshake, hold until R handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arready_r <= 1'b1;
         rvalid_r  <= 1'b0;
         rresp_r   <= RESP_OKAY;
         rdata_r   <= 32'h0;
      end else if (s_axi_arvalid && arready_r) begin
         arready_r <= 1'b0;
         rvalid_r  <= 1'b1;
         rdata_r   <= rd_data_s;
         rresp_r   <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_r && s_axi_rready) begin
         arready_r <= 1'b1;
         rvalid_r  <= 1'b0;
      end
   end

endmodule
